// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter and sequencer sharing one right-shift unit among NREQ requesters.
// Optional WAIT timeout abort is compiled in with `define SHIFT_TIMEOUT_EN.
module shift_unit_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] opa,
  input  logic [NREQ*WIDTH-1:0] opb,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic                  err,
  output logic                  u_init,
  output logic [WIDTH-1:0]      u_portA,
  output logic [WIDTH-1:0]      u_portB,
  input  logic [WIDTH-1:0]      u_out,
  input  logic                  u_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic              u_init_q, u_init_d;
  logic [WIDTH-1:0]  porta_q, porta_d;
  logic [WIDTH-1:0]  portb_q, portb_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic              found;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;

`ifdef SHIFT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Round-robin search: first asserted request at or above the pointer, with wrap.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    u_init_d    = u_init_q;
    porta_d     = porta_q;
    portb_d     = portb_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
`ifdef SHIFT_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          porta_d         = opa[int'(pick_idx)*WIDTH +: WIDTH];
          portb_d         = opb[int'(pick_idx)*WIDTH +: WIDTH];
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gidx_d          = pick_idx;
          busy_d          = 1'b1;
          u_init_d        = 1'b1;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SHIFT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // DONE is sticky in the shifter, so it is only trusted while waiting here.
        if (u_done) begin
          rsp_data_d  = u_out;
          rsp_valid_d = gnt_q;
          u_init_d    = 1'b0;
          state_d     = S_RESP;
        end
`ifdef SHIFT_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_valid_d = gnt_q;
          err_d       = 1'b1;
          u_init_d    = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      u_init_q    <= 1'b0;
      porta_q     <= '0;
      portb_q     <= '0;
      ptr_q       <= '0;
      gidx_q      <= '0;
`ifdef SHIFT_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      u_init_q    <= u_init_d;
      porta_q     <= porta_d;
      portb_q     <= portb_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
`ifdef SHIFT_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign u_init    = u_init_q;
  assign u_portA   = porta_q;
  assign u_portB   = portb_q;
`ifdef SHIFT_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with a behavioural stub shifter (programmable DONE delay).
module tb_shift_unit_arbiter;
  localparam int NREQ = 2;
  localparam int WIDTH = 3;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] opa, opb;
  logic [NREQ-1:0]       gnt, rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy, err, u_init, u_done;
  logic [WIDTH-1:0]      u_portA, u_portB, u_out;

  int n_checks = 0;
  int n_fail = 0;
  int multi_gnt = 0;
  int done_delay = 0;
  logic done_hold0 = 1'b0;
  int dcnt = 0;

  always #5 clk = ~clk;

  shift_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err),
    .u_init(u_init), .u_portA(u_portA), .u_portB(u_portB), .u_out(u_out), .u_done(u_done)
  );

  // Stub shifter: combinational shift, DONE after done_delay cycles of init.
  assign u_out  = u_portA >> u_portB;
  assign u_done = !done_hold0 && u_init && (dcnt >= done_delay);
  always @(posedge clk) dcnt <= u_init ? dcnt + 1 : 0;

  always @(negedge clk) if ($countones(gnt) > 1) multi_gnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         idx;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (|rsp_valid) break;
    end
    if (!(|rsp_valid)) chk("rsp_timeout", 32'(cycles), 32'(-1));
  endtask

  // Single-requester op with exact-latency checks; called at a negedge.
  task automatic do_op(input int idx, input logic [2:0] a, input logic [2:0] b, input logic [2:0] exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    opa[idx*WIDTH +: WIDTH] = a;
    opb[idx*WIDTH +: WIDTH] = b;
    req[idx] = 1'b1;
    @(negedge clk);
    chk("issue_gnt", 32'(gnt), 32'(oh));
    chk("issue_portA", 32'(u_portA), 32'(a));
    chk("issue_portB", 32'(u_portB), 32'(b));
    chk("issue_init", 32'(u_init), 32'd1);
    chk("issue_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("wait_init", 32'(u_init), 32'd1);
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'(oh));
    chk("resp_data", 32'(rsp_data), 32'(exp));
    chk("resp_init", 32'(u_init), 32'd0);
    req[idx] = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    $display("op req%0d a=%0d b=%0d -> rsp_data=%0d (exp %0d)", idx, a, b, rsp_data, exp);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [NREQ-1:0] exp_oh;

    vecs[0] = '{0, 3'd6, 3'd2, 3'd1};
    vecs[1] = '{1, 3'd5, 3'd1, 3'd2};
    vecs[2] = '{0, 3'd7, 3'd0, 3'd7};
    vecs[3] = '{1, 3'd7, 3'd2, 3'd1};
    vecs[4] = '{0, 3'd4, 3'd3, 3'd0};
    vecs[5] = '{1, 3'd1, 3'd0, 3'd1};
    vecs[6] = '{0, 3'd7, 3'd7, 3'd0};
    vecs[7] = '{1, 3'd6, 3'd1, 3'd3};

    rst = 1'b1;
    req = '0;
    opa = '0;
    opb = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_init", 32'(u_init), 32'd0);
    chk("rst_portA", 32'(u_portA), 32'd0);
    chk("rst_portB", 32'(u_portB), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single-requester ops
    for (int i = 0; i < 8; i++) do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Simultaneous requests after reset: requester 0 first, requester 1 four cycles later
    do_reset();
    opa = {3'd5, 3'd7};
    opb = {3'd0, 3'd1};
    req = 2'b11;
    wait_rsp(20, cyc);
    chk("simul_first_lat", 32'(cyc), 32'd3);
    chk("simul_first_valid", 32'(rsp_valid), 32'b01);
    chk("simul_first_data", 32'(rsp_data), 32'd3);
    req[0] = 1'b0;
    wait_rsp(20, cyc);
    chk("simul_second_lat", 32'(cyc), 32'd4);
    chk("simul_second_valid", 32'(rsp_valid), 32'b10);
    chk("simul_second_data", 32'(rsp_data), 32'd5);
    $display("simultaneous: second response rsp_data=%0d after %0d cycles", rsp_data, cyc);
    req[1] = 1'b0;
    @(negedge clk);

    // Fairness: both held through six grants
    multi_gnt = 0;
    req = 2'b11;
    for (int g = 0; g < 6; g++) begin
      exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
      wait_rsp(20, cyc);
      chk("rr_order", 32'(rsp_valid), 32'(exp_oh));
      $display("rr grant %0d: rsp_valid=%b", g, rsp_valid);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_multi_gnt", 32'(multi_gnt), 32'd0);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Operand change after grant is ignored
    opa[2:0] = 3'd7;
    opb[2:0] = 3'd3;
    req[0] = 1'b1;
    @(negedge clk);
    opb[2:0] = 3'd0;
    opa[2:0] = 3'd4;
    wait_rsp(20, cyc);
    chk("latch_portB", 32'(u_portB), 32'd3);
    chk("latch_data0", 32'(rsp_data), 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    opa[2:0] = 3'd6;
    opb[2:0] = 3'd1;
    req[0] = 1'b1;
    @(negedge clk);
    opb[2:0] = 3'd0;
    wait_rsp(20, cyc);
    chk("latch_data3", 32'(rsp_data), 32'd3);
    $display("latched op: rsp_data=%0d", rsp_data);
    req[0] = 1'b0;
    @(negedge clk);

    // Reset during WAIT with delayed DONE; pointer returns to 0
    do_op(0, 3'd4, 3'd1, 3'd2);
    done_delay = 5;
    opa[5:3] = 3'd5;
    opb[5:3] = 3'd1;
    req[1] = 1'b1;
    @(negedge clk);
    chk("dly_gnt", 32'(gnt), 32'b10);
    @(negedge clk);
    @(negedge clk);
    chk("dly_wait_init", 32'(u_init), 32'd1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_init", 32'(u_init), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    done_delay = 0;
    opa = {3'd6, 3'd6};
    opb = {3'd1, 3'd1};
    req = 2'b11;
    @(negedge clk);
    chk("abort_ptr0", 32'(gnt), 32'b01);
    wait_rsp(20, cyc);
    chk("abort_after_data", 32'(rsp_data), 32'd3);
    $display("post-abort op: rsp_valid=%b rsp_data=%0d", rsp_valid, rsp_data);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // DONE never arrives
    done_hold0 = 1'b1;
    req[0] = 1'b1;
`ifdef SHIFT_TIMEOUT_EN
    seen = 0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (err && !(|rsp_valid)) seen++;
      if (|rsp_valid) break;
    end
    chk("to_latency", 32'(cyc), 32'(TIMEOUT + 2));
    chk("to_err", 32'(err), 32'd1);
    chk("to_valid", 32'(rsp_valid), 32'b01);
    chk("to_data", 32'(rsp_data), 32'd0);
    chk("to_err_early", 32'(seen), 32'd0);
    req = '0;
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    $display("timeout op: latency=%0d", cyc);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((|rsp_valid) || err) seen++;
    end
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_no_rsp", 32'(seen), 32'd0);
    chk("hang_init", 32'(u_init), 32'd1);
    $display("no-timeout op: still busy after 40 cycles");
    do_reset();
    chk("hang_reset_busy", 32'(busy), 32'd0);
`endif
    done_hold0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
